// File: rtl/alu_station.sv
// ALU reservation station: holds dispatched ALU ops until both operands are
// available, captures operands from the CDB and issues one op per cycle by index priority.

package alu_station_pkg;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, LUI, AUIPC
    } instr_name_e;

endpackage

module alu_station
    import alu_station_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_disp_valid,
    input  instr_name_e       i_instr_name,
    input  logic [31:0]       i_address,
    input  logic [31:0]       i_immediate,
    input  logic [31:0]       i_data_1,
    input  logic [31:0]       i_data_2,
    input  logic              i_rdy_1,
    input  logic              i_rdy_2,
    input  logic [TAG_W-1:0]  i_tag_1,
    input  logic [TAG_W-1:0]  i_tag_2,
    input  logic [TAG_W-1:0]  i_rd_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [31:0]       i_cdb_data,
    output logic              o_full,
    output logic              o_issue_valid,
    input  logic              i_issue_ready,
    output logic [31:0]       o_data_1,
    output logic [31:0]       o_data_2,
    output logic [31:0]       o_address,
    output logic [31:0]       o_immediate,
    output instr_name_e       o_instr_name,
    output logic [TAG_W-1:0]  o_rd_tag
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Entry control state (reset) and payload (no reset needed, guarded by busy/ready)
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] rdy1;
    logic [DEPTH-1:0] rdy2;

    instr_name_e      ent_name [DEPTH];
    logic [XLEN-1:0]  ent_addr [DEPTH];
    logic [XLEN-1:0]  ent_imm  [DEPTH];
    logic [TAG_W-1:0] ent_rd   [DEPTH];
    logic [XLEN-1:0]  val1     [DEPTH];
    logic [XLEN-1:0]  val2     [DEPTH];
    logic [TAG_W-1:0] tag1     [DEPTH];
    logic [TAG_W-1:0] tag2     [DEPTH];

    logic [DEPTH-1:0] eligible;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             any_elig;
    logic             disp_accept;
    logic             issue_load;
    logic             byp1;
    logic             byp2;

    assign o_full      = &busy;
    assign eligible    = busy & rdy1 & rdy2;
    assign any_elig    = |eligible;
    assign disp_accept = i_disp_valid & ~o_full & ~i_flush;
    assign issue_load  = ~o_issue_valid | i_issue_ready;
    assign byp1        = i_cdb_valid && (i_cdb_tag == i_tag_1);
    assign byp2        = i_cdb_valid && (i_cdb_tag == i_tag_2);

    // Lowest-index free slot and lowest-index ready slot; scan high-to-low so the lowest wins
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
            if (eligible[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Busy/ready bookkeeping and the issue register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            busy          <= '0;
            rdy1          <= '0;
            rdy2          <= '0;
            o_issue_valid <= 1'b0;
            o_data_1      <= '0;
            o_data_2      <= '0;
            o_address     <= '0;
            o_immediate   <= '0;
            o_instr_name  <= ADD;
            o_rd_tag      <= '0;
        end else if (i_flush) begin
            busy          <= '0;
            o_issue_valid <= 1'b0;
        end else begin
            if (issue_load) begin
                o_issue_valid <= any_elig;
                if (any_elig) begin
                    o_data_1     <= val1[sel_idx];
                    o_data_2     <= val2[sel_idx];
                    o_address    <= ent_addr[sel_idx];
                    o_immediate  <= ent_imm[sel_idx];
                    o_instr_name <= ent_name[sel_idx];
                    o_rd_tag     <= ent_rd[sel_idx];
                end
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (busy[i] && !rdy1[i] && i_cdb_valid && (tag1[i] == i_cdb_tag)) begin
                    rdy1[i] <= 1'b1;
                end
                if (busy[i] && !rdy2[i] && i_cdb_valid && (tag2[i] == i_cdb_tag)) begin
                    rdy2[i] <= 1'b1;
                end
                if (issue_load && any_elig && (sel_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b0;
                end
                // Dispatch only targets a non-busy slot, so it never collides with wakeup or issue
                if (disp_accept && (free_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b1;
                    rdy1[i] <= i_rdy_1 | byp1;
                    rdy2[i] <= i_rdy_2 | byp2;
                end
            end
        end
    end

    // Entry payload: dispatch write and CDB operand capture
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (busy[i] && !rdy1[i] && i_cdb_valid && (tag1[i] == i_cdb_tag)) begin
                val1[i] <= i_cdb_data;
            end
            if (busy[i] && !rdy2[i] && i_cdb_valid && (tag2[i] == i_cdb_tag)) begin
                val2[i] <= i_cdb_data;
            end
            if (disp_accept && (free_idx == IDX_W'(i))) begin
                ent_name[i] <= i_instr_name;
                ent_addr[i] <= i_address;
                ent_imm[i]  <= i_immediate;
                ent_rd[i]   <= i_rd_tag;
                tag1[i]     <= i_tag_1;
                tag2[i]     <= i_tag_2;
                val1[i]     <= i_rdy_1 ? i_data_1 : i_cdb_data;
                val2[i]     <= i_rdy_2 ? i_data_2 : i_cdb_data;
            end
        end
    end

endmodule
